eng_pipe_sched: RTL and testbench

Issue scheduler for the engine pipeline: arbitrates commands from N_REQ requesters into the single engine pipe, round-robin. Enforces one in-flight command per queue context through a hazard scoreboard, and caps outstanding commands at PIPE_DEPTH with a credit counter. Sits between the per-port command front-ends and the engine pipe; retirements from the pipe return here to release contexts and credits.

---
 rtl/eng_pipe_sched_pkg.sv | 23 ++
 rtl/eng_pipe_sched_rr_arb.sv | 40 ++++
 rtl/eng_pipe_sched.sv | 143 ++++++++++++++
 tb/tb_eng_pipe_sched.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/eng_pipe_sched_pkg.sv
// Shared types and default parameters for the engine pipe scheduler.
//   q_pkg   : op_t command opcode enum and the default context id width.
//   cfg_pkg : default requester count and pipe depth (outstanding-credit limit).

package q_pkg;

  typedef enum logic [1:0] {
    OP_PUSH  = 2'd0,
    OP_POP   = 2'd1,
    OP_PEEK  = 2'd2,
    OP_FLUSH = 2'd3
  } op_t;

  localparam int unsigned CTX_W_DEF = 3;

endpackage : q_pkg

package cfg_pkg;

  localparam int unsigned N_REQ_DEF      = 4;
  localparam int unsigned PIPE_DEPTH_DEF = 4;

endpackage : cfg_pkg

// File: rtl/eng_pipe_sched_rr_arb.sv
// eng_rr_arb: purely combinational N-way round-robin arbiter.
// The search starts at ptr and wraps, so the first set request at or
// after ptr wins. The pointer register is owned by the caller.
//   req : request vector (N)
//   ptr : search start index
//   gnt : one-hot grant (all zero when no request)
//   idx : encoded index of the granted request (0 when none)
//   vld : a grant was made this cycle

module eng_rr_arb #(
  parameter  int unsigned N     = 4,
  localparam int unsigned IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx,
  output logic             vld
);

  logic [IDX_W-1:0] cand;

  // N is a power of two, so the wrap is simply the natural truncation
  // of ptr + k to IDX_W bits.
  always_comb begin
    gnt  = '0;
    idx  = '0;
    vld  = 1'b0;
    cand = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = ptr + IDX_W'(k);
      if (!vld && req[cand]) begin
        vld       = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule : eng_rr_arb

// File: rtl/eng_pipe_sched.sv
// eng_pipe_sched: issue scheduler for the engine pipe.
// Round-robin arbitration of N_REQ requesters into a single registered
// issue slot, with a per-context hazard scoreboard (one in-flight command
// per context) and a credit counter capping outstanding commands at
// PIPE_DEPTH. Retirements from the pipe release contexts and credits.
//   clk, arst          : clock, asynchronous active-high reset
//   req_vld/ctx/op     : per-requester command (packed, requester i at i*W)
//   req_gnt            : combinational one-hot grant
//   iss_vld/ctx/op/src : registered issue slot, iss_rdy accepts it
//   ret_vld/ret_ctx    : retire pulse from the pipe
//   busy               : issue slot occupied or commands outstanding
//   err_ret            : sticky, retire seen for a context not in flight

module eng_pipe_sched
  import q_pkg::*;
  import cfg_pkg::*;
#(
  parameter int unsigned N_REQ      = N_REQ_DEF,
  parameter int unsigned CTX_W      = CTX_W_DEF,
  parameter int unsigned PIPE_DEPTH = PIPE_DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       arst,
  input  logic [N_REQ-1:0]           req_vld,
  input  logic [N_REQ*CTX_W-1:0]     req_ctx,
  input  logic [N_REQ*2-1:0]         req_op,
  output logic [N_REQ-1:0]           req_gnt,
  output logic                       iss_vld,
  output logic [CTX_W-1:0]           iss_ctx,
  output logic [1:0]                 iss_op,
  output logic [$clog2(N_REQ)-1:0]   iss_src,
  input  logic                       iss_rdy,
  input  logic                       ret_vld,
  input  logic [CTX_W-1:0]           ret_ctx,
  output logic                       busy,
  output logic                       err_ret
);

  localparam int unsigned SRC_W = $clog2(N_REQ);
  localparam int unsigned CNT_W = $clog2(PIPE_DEPTH + 1);
  localparam int unsigned N_CTX = 1 << CTX_W;

  logic [N_CTX-1:0] sb;
  logic [N_CTX-1:0] sb_nxt;
  logic [CNT_W-1:0] cnt;
  logic [SRC_W-1:0] ptr;
  op_t              iss_op_q;

  logic [CTX_W-1:0] ctx_of [N_REQ];
  op_t              op_of  [N_REQ];

  logic             slot_free;
  logic             credit_ok;
  logic [N_REQ-1:0] elig;
  logic [N_REQ-1:0] arb_gnt;
  logic [SRC_W-1:0] arb_idx;
  logic             arb_vld;
  logic [CTX_W-1:0] gnt_ctx;
  op_t              gnt_op;
  logic             ret_hit;

  always_comb begin
    for (int unsigned i = 0; i < N_REQ; i++) begin
      ctx_of[i] = req_ctx[i*CTX_W +: CTX_W];
      op_of[i]  = op_t'(req_op[i*2 +: 2]);
    end
  end

  assign slot_free = !iss_vld || iss_rdy;
  assign credit_ok = (cnt < CNT_W'(PIPE_DEPTH));

  // Eligibility uses registered sb/cnt only: a retire this cycle is not
  // visible to arbitration until the next cycle.
  always_comb begin
    elig = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      elig[i] = req_vld[i] && !sb[ctx_of[i]] && credit_ok && slot_free;
    end
  end

  eng_rr_arb #(
    .N (N_REQ)
  ) u_arb (
    .req (elig),
    .ptr (ptr),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .vld (arb_vld)
  );

  // Grant is forced off while reset is held so nothing is handshaken
  // with the front-ends during reset.
  assign req_gnt = arst ? '0 : arb_gnt;
  assign gnt_ctx = ctx_of[arb_idx];
  assign gnt_op  = op_of[arb_idx];

  assign ret_hit = ret_vld && sb[ret_ctx];

  // A granted context has sb=0 and a hit retire needs sb=1, so the set and
  // clear can never target the same entry in one cycle.
  always_comb begin
    sb_nxt = sb;
    if (ret_hit) sb_nxt[ret_ctx] = 1'b0;
    if (arb_vld) sb_nxt[gnt_ctx] = 1'b1;
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      sb       <= '0;
      cnt      <= '0;
      ptr      <= '0;
      iss_vld  <= 1'b0;
      iss_ctx  <= '0;
      iss_op_q <= OP_PUSH;
      iss_src  <= '0;
      err_ret  <= 1'b0;
    end else begin
      sb <= sb_nxt;

      case ({arb_vld, ret_hit})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase

      if (arb_vld) begin
        ptr      <= arb_idx + SRC_W'(1);
        iss_vld  <= 1'b1;
        iss_ctx  <= gnt_ctx;
        iss_op_q <= gnt_op;
        iss_src  <= arb_idx;
      end else if (slot_free) begin
        iss_vld <= 1'b0;
      end

      if (ret_vld && !sb[ret_ctx]) err_ret <= 1'b1;
    end
  end

  assign iss_op = iss_op_q;
  assign busy   = iss_vld || (cnt != '0);

endmodule : eng_pipe_sched

// File: tb/tb_eng_pipe_sched.sv
module tb_eng_pipe_sched;

  logic        clk;
  logic        arst;
  logic [3:0]  req_vld;
  logic [11:0] req_ctx;
  logic [7:0]  req_op;
  logic [3:0]  req_gnt;
  logic        iss_vld;
  logic [2:0]  iss_ctx;
  logic [1:0]  iss_op;
  logic [1:0]  iss_src;
  logic        iss_rdy;
  logic        ret_vld;
  logic [2:0]  ret_ctx;
  logic        busy;
  logic        err_ret;

  int n_chk;
  int n_fail;

  eng_pipe_sched #(
    .N_REQ      (4),
    .CTX_W      (3),
    .PIPE_DEPTH (4)
  ) dut (
    .clk     (clk),
    .arst    (arst),
    .req_vld (req_vld),
    .req_ctx (req_ctx),
    .req_op  (req_op),
    .req_gnt (req_gnt),
    .iss_vld (iss_vld),
    .iss_ctx (iss_ctx),
    .iss_op  (iss_op),
    .iss_src (iss_src),
    .iss_rdy (iss_rdy),
    .ret_vld (ret_vld),
    .ret_ctx (ret_ctx),
    .busy    (busy),
    .err_ret (err_ret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [2:0] c, input logic [1:0] o);
    req_vld[i]         = v;
    req_ctx[i*3 +: 3]  = c;
    req_op[i*2 +: 2]   = o;
  endtask

  task automatic chk_iss(input string tag, input logic [2:0] c, input logic [1:0] o, input logic [1:0] s);
    chk({tag, "_vld"}, 32'(iss_vld), 32'd1);
    chk({tag, "_ctx"}, 32'(iss_ctx), 32'(c));
    chk({tag, "_op"},  32'(iss_op),  32'(o));
    chk({tag, "_src"}, 32'(iss_src), 32'(s));
  endtask

  initial begin
    n_chk   = 0;
    n_fail  = 0;
    arst    = 1'b1;
    req_vld = '0;
    req_ctx = '0;
    req_op  = '0;
    iss_rdy = 1'b1;
    ret_vld = 1'b0;
    ret_ctx = '0;

    // Reset state with all requesters valid: no grant may leak out.
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, 3'(i), 2'(i));
    #2;
    chk("rst_gnt",  32'(req_gnt), 32'h0);
    chk("rst_iss",  32'(iss_vld), 32'd0);
    chk("rst_busy", 32'(busy),    32'd0);
    chk("rst_err",  32'(err_ret), 32'd0);

    // Back-to-back issue of ctx 0..3 in RR order, then credits exhausted.
    tick();
    arst = 1'b0;
    #1;
    chk("rr_gnt0", 32'(req_gnt), 32'b0001);
    tick();
    chk_iss("rr_iss0", 3'd0, 2'd0, 2'd0);
    chk("rr_gnt1", 32'(req_gnt), 32'b0010);
    tick();
    chk_iss("rr_iss1", 3'd1, 2'd1, 2'd1);
    chk("rr_gnt2", 32'(req_gnt), 32'b0100);
    tick();
    chk_iss("rr_iss2", 3'd2, 2'd2, 2'd2);
    chk("rr_gnt3", 32'(req_gnt), 32'b1000);
    tick();
    chk_iss("rr_iss3", 3'd3, 2'd3, 2'd3);
    set_req(0, 1'b1, 3'd4, 2'd0);
    #1;
    chk("full_gnt",  32'(req_gnt), 32'h0);
    chk("full_busy", 32'(busy),    32'd1);
    tick();
    chk("idle_iss",  32'(iss_vld), 32'd0);
    chk("idle_busy", 32'(busy),    32'd1);
    chk("idle_ctx",  32'(iss_ctx), 32'd3);

    // Retire coincident with a pending request: grant only the next cycle.
    req_vld = '0;
    set_req(0, 1'b1, 3'd6, 2'd2);
    ret_vld = 1'b1;
    ret_ctx = 3'd0;
    #1;
    chk("nobyp_gnt", 32'(req_gnt), 32'h0);
    tick();
    ret_vld = 1'b0;
    #1;
    chk("ret_gnt", 32'(req_gnt), 32'b0001);
    tick();
    chk_iss("ret_iss", 3'd6, 2'd2, 2'd0);
    set_req(0, 1'b0, 3'd6, 2'd2);
    set_req(1, 1'b1, 3'd4, 2'd0);
    #1;
    chk("cnt4_gnt", 32'(req_gnt), 32'h0);

    // Retire to an idle context: sticky error, credits unchanged.
    ret_vld = 1'b1;
    ret_ctx = 3'd7;
    tick();
    ret_vld = 1'b0;
    #1;
    chk("err_set",   32'(err_ret), 32'd1);
    chk("err_cnt",   32'(req_gnt), 32'h0);
    tick();
    chk("err_stick", 32'(err_ret), 32'd1);

    // Drain ctx 1..3, then grant requester 3 so the pointer wraps to 0.
    req_vld = '0;
    for (int c = 1; c <= 3; c++) begin
      ret_vld = 1'b1;
      ret_ctx = 3'(c);
      tick();
    end
    ret_vld = 1'b0;
    set_req(3, 1'b1, 3'd0, 2'd1);
    #1;
    chk("wrap_gnt", 32'(req_gnt), 32'b1000);
    tick();
    set_req(3, 1'b0, 3'd0, 2'd1);
    chk_iss("wrap_iss", 3'd0, 2'd1, 2'd3);

    // Same-context collision on ctx 5 between requesters 1 and 2.
    set_req(1, 1'b1, 3'd5, 2'd0);
    set_req(2, 1'b1, 3'd5, 2'd3);
    #1;
    chk("coll_gnt", 32'(req_gnt), 32'b0010);
    tick();
    chk_iss("coll_iss", 3'd5, 2'd0, 2'd1);
    set_req(1, 1'b0, 3'd5, 2'd0);
    #1;
    chk("coll_blk0", 32'(req_gnt), 32'h0);
    tick();
    chk("coll_blk1", 32'(req_gnt), 32'h0);
    ret_vld = 1'b1;
    ret_ctx = 3'd5;
    #1;
    chk("coll_blk_ret", 32'(req_gnt), 32'h0);
    tick();
    ret_vld = 1'b0;
    #1;
    chk("coll_regnt", 32'(req_gnt), 32'b0100);
    tick();
    chk_iss("coll_iss2", 3'd5, 2'd3, 2'd2);
    req_vld = '0;

    // Back-pressure: payload frozen and no grants while iss_rdy is low.
    iss_rdy = 1'b0;
    set_req(0, 1'b1, 3'd1, 2'd1);
    #1;
    chk("bp_gnt", 32'(req_gnt), 32'h0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_iss("bp_hold", 3'd5, 2'd3, 2'd2);
      chk("bp_gnt_hold", 32'(req_gnt), 32'h0);
    end
    iss_rdy = 1'b1;
    #1;
    chk("bp_rel_gnt", 32'(req_gnt), 32'b0001);
    tick();
    chk_iss("bp_rel_iss", 3'd1, 2'd1, 2'd0);
    req_vld = '0;

    // Mid-operation reset with cnt=3 and the issue slot occupied.
    iss_rdy = 1'b0;
    ret_vld = 1'b1;
    ret_ctx = 3'd0;
    tick();
    ret_vld = 1'b0;
    chk("pre_rst_iss", 32'(iss_vld), 32'd1);
    iss_rdy = 1'b1;
    set_req(0, 1'b1, 3'd2, 2'd0);
    #1;
    chk("pre_rst_gnt", 32'(req_gnt), 32'b0001);
    arst = 1'b1;
    #1;
    chk("mrst_gnt",  32'(req_gnt), 32'h0);
    chk("mrst_vld",  32'(iss_vld), 32'd0);
    chk("mrst_ctx",  32'(iss_ctx), 32'd0);
    chk("mrst_op",   32'(iss_op),  32'd0);
    chk("mrst_src",  32'(iss_src), 32'd0);
    chk("mrst_busy", 32'(busy),    32'd0);
    chk("mrst_err",  32'(err_ret), 32'd0);
    tick();
    arst = 1'b0;
    req_vld = '0;
    set_req(2, 1'b1, 3'd5, 2'd2);
    #1;
    chk("post_rst_gnt", 32'(req_gnt), 32'b0100);
    tick();
    chk_iss("post_rst_iss", 3'd5, 2'd2, 2'd2);
    chk("post_rst_busy", 32'(busy), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule : tb_eng_pipe_sched
